sequence_controller: RTL and testbench

Instruction-cycle sequencer for the basic-computer datapath. Owns the 3-bit sequence counter (SC), the run/halt flip-flop and the instruction-field latch. It drives the one-hot timing vector `T`, the decoded opcode `D`, the indirect bit `I` and the register-reference field `B` that every control-signal block consumes. SC clearing comes back from the SC control logic; `start`, `stop` and `step` form the front-panel run control.

---
 rtl/sequence_controller_pkg.sv | 47 ++++
 rtl/sequence_controller_decoder.sv | 16 +
 rtl/sequence_controller.sv | 142 ++++++++++++++
 tb/tb_sequence_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_controller_pkg.sv
// Shared definitions for the instruction-cycle sequencer: counter widths,
// IR field positions, the HLT encoding and the opcode indices.
package sequence_controller_pkg;

  // Sequence-counter width; the timing vector is one-hot over 2^SC_W_DEF states
  localparam int unsigned SC_W_DEF = 3;
  localparam int unsigned T_W_DEF  = 1 << SC_W_DEF;

  // IR field layout: {I, opcode[2:0], address/B[3:0]}
  localparam int unsigned IR_W   = 8;
  localparam int unsigned I_BIT  = 7;
  localparam int unsigned OP_MSB = 6;
  localparam int unsigned OP_LSB = 4;
  localparam int unsigned B_MSB  = 3;
  localparam int unsigned B_LSB  = 0;
  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;
  localparam int unsigned B_F_W  = B_MSB - B_LSB + 1;

  // Opcode indices as decoded onto D
  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_REG = 3'd7
  } opcode_e;

  // HLT is the register-reference instruction with an all-zero B field
  localparam logic [OP_W-1:0]  HLT_OP = OP_REG;
  localparam logic             HLT_I  = 1'b0;
  localparam logic [B_F_W-1:0] HLT_B  = 4'h0;

  // Run/halt flip-flop
  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  function automatic logic is_hlt(input logic i, input logic [OP_W-1:0] op,
                                  input logic [B_F_W-1:0] b);
    return (op == HLT_OP) && (i == HLT_I) && (b == HLT_B);
  endfunction

endpackage

// File: rtl/sequence_controller_decoder.sv
// Enabled binary-to-one-hot decoder used for the timing vector and the opcode decode.
module onehot_decoder3to8 #(
  parameter int unsigned IN_W = 3
) (
  input  logic                   i_en,
  input  logic [IN_W-1:0]        i_sel,
  output logic [(1<<IN_W)-1:0]   o_onehot
);

  // Single hot bit at the selected index, all zero when disabled
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/sequence_controller.sv
// Instruction-cycle sequencer: sequence counter, run/halt control with
// stop/step handling, IR field latch and the T/D decode outputs.
// Optional feature: define INSTR_COUNT_EN to build the retired-instruction counter.
module sequence_controller
  import sequence_controller_pkg::*;
#(
  parameter int unsigned SC_W  = SC_W_DEF,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic [IR_W-1:0]       ir,
  input  logic                  clr_sc,
  output logic [(1<<SC_W)-1:0]  T,
  output logic [T_W_DEF-1:0]    D,
  output logic                  I,
  output logic [T_W_DEF-1:0]    B,
  output logic                  running,
  output logic                  sc_overflow,
  output logic [CNT_W-1:0]      instr_count
);

  run_state_e         r_state, w_state_nxt;
  logic [SC_W-1:0]    r_sc, w_sc_nxt;
  logic               r_stop_pend, w_stop_pend_nxt;
  logic               r_step_mode, w_step_mode_nxt;
  logic               r_sc_overflow, w_sc_overflow_nxt;
  logic               r_i;
  logic [OP_W-1:0]    r_op;
  logic [B_F_W-1:0]   r_b;

  logic w_run;
  logic w_hlt;
  logic w_boundary;

  assign w_run      = (r_state == ST_RUN);
  assign w_hlt      = w_run && (r_sc == SC_W'(3)) && is_hlt(r_i, r_op, r_b);
  assign w_boundary = w_run && (clr_sc || w_hlt);

  // State registers for the sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_HALT;
      r_sc          <= '0;
      r_stop_pend   <= 1'b0;
      r_step_mode   <= 1'b0;
      r_sc_overflow <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sc          <= w_sc_nxt;
      r_stop_pend   <= w_stop_pend_nxt;
      r_step_mode   <= w_step_mode_nxt;
      r_sc_overflow <= w_sc_overflow_nxt;
    end
  end

  // Next-state logic: run control, SC advance/clear, stop capture, overflow
  always_comb begin
    w_state_nxt       = r_state;
    w_sc_nxt          = r_sc;
    w_stop_pend_nxt   = r_stop_pend;
    w_step_mode_nxt   = r_step_mode;
    w_sc_overflow_nxt = r_sc_overflow;
    case (r_state)
      ST_HALT: begin
        w_sc_nxt = '0;
        if (start) begin
          w_state_nxt     = ST_RUN;
          w_step_mode_nxt = 1'b0;
        end else if (step) begin
          w_state_nxt     = ST_RUN;
          w_step_mode_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        w_stop_pend_nxt = r_stop_pend | stop;
        if (clr_sc || w_hlt) begin
          w_sc_nxt = '0;
        end else begin
          w_sc_nxt = r_sc + SC_W'(1);
          if (r_sc == '1) w_sc_overflow_nxt = 1'b1;
        end
        if (w_hlt) w_state_nxt = ST_HALT;
        // A live stop on the boundary edge counts as well as a pending one
        if (w_boundary && (r_stop_pend || stop || r_step_mode)) begin
          w_state_nxt     = ST_HALT;
          w_stop_pend_nxt = 1'b0;
          w_step_mode_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  // Instruction field latch, loaded on the edge that ends T2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i  <= 1'b0;
      r_op <= '0;
      r_b  <= '0;
    end else if (w_run && (r_sc == SC_W'(2))) begin
      r_i  <= ir[I_BIT];
      r_op <= ir[OP_MSB:OP_LSB];
      r_b  <= ir[B_MSB:B_LSB];
    end
  end

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] r_instr_count;

  // Retired-instruction counter, one count per boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_instr_count <= '0;
    else if (w_boundary) r_instr_count <= r_instr_count + CNT_W'(1);
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = '0;
`endif

  onehot_decoder3to8 #(.IN_W(SC_W)) u_t_dec (
    .i_en     (w_run),
    .i_sel    (r_sc),
    .o_onehot (T)
  );

  onehot_decoder3to8 #(.IN_W(OP_W)) u_d_dec (
    .i_en     (1'b1),
    .i_sel    (r_op),
    .o_onehot (D)
  );

  assign I           = r_i;
  assign B           = {{(T_W_DEF - B_F_W){1'b0}}, r_b};
  assign running     = w_run;
  assign sc_overflow = r_sc_overflow;

endmodule

// File: tb/tb_sequence_controller.sv
// Self-checking bench for sequence_controller: directed scenarios from the
// test plan followed by randomized instructions against an instruction-level model.
module tb_sequence_controller;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        start  = 1'b0;
  logic        stop   = 1'b0;
  logic        step   = 1'b0;
  logic        clr_sc = 1'b0;
  logic [7:0]  ir     = 8'h00;
  logic [7:0]  T, D, B;
  logic        I, running, sc_overflow;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;

  // Model state: retired instructions and sticky overflow
  logic [15:0] exp_count = '0;
  logic        exp_ovf   = 1'b0;

`ifdef INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  sequence_controller #(.SC_W(3), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .ir          (ir),
    .clr_sc      (clr_sc),
    .T           (T),
    .D           (D),
    .I           (I),
    .B           (B),
    .running     (running),
    .sc_overflow (sc_overflow),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] cnt_model();
    return CNT_EN ? exp_count : 16'h0000;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    tick(); tick();
    exp_count = '0; exp_ovf = 1'b0;
    checks++; if (T !== 8'h00) begin failures++; $display("FAIL reset_T got=%h exp=00", T); end
    checks++; if (D !== 8'h01) begin failures++; $display("FAIL reset_D got=%h exp=01", D); end
    checks++; if (B !== 8'h00) begin failures++; $display("FAIL reset_B got=%h exp=00", B); end
    checks++; if (I !== 1'b0) begin failures++; $display("FAIL reset_I got=%b exp=0", I); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (sc_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", sc_overflow); end
    checks++; if (instr_count !== cnt_model()) begin failures++; $display("FAIL reset_count got=%0d exp=%0d", instr_count, cnt_model()); end
    rst_n = 1'b1;
    tick();
    checks++; if (T !== 8'h00) begin failures++; $display("FAIL reset_idle_T got=%h exp=00", T); end
  endtask

  // start pulse, ir=20 (LDA), clr_sc at T5, then straight into the next T0
  task automatic test_basic_instr();
    logic [7:0] et;
    ir = 8'h20; start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      clr_sc = (c == 5);
      et = 8'h01 << c;
      checks++; if (T !== et) begin failures++; $display("FAIL basic_T c=%0d got=%h exp=%h", c, T, et); end
      if (c >= 3) begin
        checks++; if (D !== 8'h04) begin failures++; $display("FAIL basic_D c=%0d got=%h exp=04", c, D); end
      end
      tick();
    end
    clr_sc = 1'b0; exp_count++;
    checks++; if (T !== 8'h01) begin failures++; $display("FAIL basic_next_T0 got=%h exp=01", T); end
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL basic_running got=%b exp=1", running); end
    checks++; if (instr_count !== cnt_model()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", instr_count, cnt_model()); end
  endtask

  // HLT halts on the T3 edge; start resumes with T0 the next cycle
  task automatic test_hlt();
    logic [7:0] et;
    ir = 8'h70;
    for (int c = 0; c <= 3; c++) begin
      et = 8'h01 << c;
      checks++; if (T !== et) begin failures++; $display("FAIL hlt_T c=%0d got=%h exp=%h", c, T, et); end
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL hlt_running c=%0d got=%b exp=1", c, running); end
      tick();
    end
    exp_count++;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL hlt_halted got=%b exp=0", running); end
    checks++; if (T !== 8'h00) begin failures++; $display("FAIL hlt_T_idle got=%h exp=00", T); end
    checks++; if (instr_count !== cnt_model()) begin failures++; $display("FAIL hlt_count got=%0d exp=%0d", instr_count, cnt_model()); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (T !== 8'h01) begin failures++; $display("FAIL hlt_restart_T got=%h exp=01", T); end
  endtask

  // stop during T1 defers the halt to the T5 boundary
  task automatic test_stop();
    logic [7:0] et;
    ir = 8'h10;
    for (int c = 0; c <= 5; c++) begin
      stop = (c == 1); clr_sc = (c == 5);
      et = 8'h01 << c;
      checks++; if (T !== et) begin failures++; $display("FAIL stop_T c=%0d got=%h exp=%h", c, T, et); end
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL stop_early c=%0d got=%b exp=1", c, running); end
      tick();
    end
    stop = 1'b0; clr_sc = 1'b0; exp_count++;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_halted got=%b exp=0", running); end
    checks++; if (T !== 8'h00) begin failures++; $display("FAIL stop_T_idle got=%h exp=00", T); end
  endtask

  // single step of CLA (ir=78) ending at T3
  task automatic test_step_cla();
    logic [7:0] et;
    ir = 8'h78; step = 1'b1; tick(); step = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      clr_sc = (c == 3);
      et = 8'h01 << c;
      checks++; if (T !== et) begin failures++; $display("FAIL step_T c=%0d got=%h exp=%h", c, T, et); end
      if (c == 3) begin
        checks++; if (B !== 8'h08) begin failures++; $display("FAIL step_B got=%h exp=08", B); end
        checks++; if (D !== 8'h80) begin failures++; $display("FAIL step_D got=%h exp=80", D); end
        checks++; if (I !== 1'b0) begin failures++; $display("FAIL step_I got=%b exp=0", I); end
      end
      tick();
    end
    clr_sc = 1'b0; exp_count++;
    checks++; if (T !== 8'h00) begin failures++; $display("FAIL step_T_idle got=%h exp=00", T); end
    tick();
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL step_stays_halted got=%b exp=0", running); end
  endtask

  // clr_sc withheld past T7: wrap to T0 and sticky overflow
  task automatic test_overflow();
    logic [7:0] et;
    ir = 8'h00; start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      clr_sc = (c == 9);
      et = 8'h01 << (c % 8);
      checks++; if (T !== et) begin failures++; $display("FAIL ovf_T c=%0d got=%h exp=%h", c, T, et); end
      checks++; if (sc_overflow !== (c >= 8)) begin failures++; $display("FAIL ovf_flag c=%0d got=%b exp=%b", c, sc_overflow, (c >= 8)); end
      tick();
    end
    clr_sc = 1'b0; exp_count++; exp_ovf = 1'b1;
    checks++; if (sc_overflow !== exp_ovf) begin failures++; $display("FAIL ovf_sticky got=%b exp=%b", sc_overflow, exp_ovf); end
    checks++; if (T !== 8'h01) begin failures++; $display("FAIL ovf_next_T0 got=%h exp=01", T); end
  endtask

  // reset asserted mid-cycle during T4 clears everything without a clock
  task automatic test_async_reset();
    ir = 8'h30;
    for (int c = 0; c < 4; c++) tick();
    checks++; if (T !== 8'h10) begin failures++; $display("FAIL areset_T4 got=%h exp=10", T); end
    #2 rst_n = 1'b0;
    #1;
    exp_count = '0; exp_ovf = 1'b0;
    checks++; if (T !== 8'h00) begin failures++; $display("FAIL areset_T got=%h exp=00", T); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL areset_running got=%b exp=0", running); end
    checks++; if (D !== 8'h01) begin failures++; $display("FAIL areset_D got=%h exp=01", D); end
    checks++; if (instr_count !== cnt_model()) begin failures++; $display("FAIL areset_count got=%0d exp=%0d", instr_count, cnt_model()); end
    checks++; if (sc_overflow !== 1'b0) begin failures++; $display("FAIL areset_ovf got=%b exp=0", sc_overflow); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (T !== 8'h00) begin failures++; $display("FAIL areset_idle_T got=%h exp=00", T); end
  endtask

  // Random instructions: each has a clear point k (k>=8 wraps), an optional
  // stop pulse at s, and may be HLT; the model works per instruction.
  task automatic test_random();
    bit         model_run  = 1'b0;
    bit         model_step = 1'b0;
    bit         hlt, halt;
    int         cmd, k, s, e;
    logic [7:0] ir_v, et, ed, eb;
    for (int it = 0; it < 60; it++) begin
      if (!model_run) begin
        checks++; if (T !== 8'h00) begin failures++; $display("FAIL rand_idle_T it=%0d got=%h exp=00", it, T); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL rand_idle_run it=%0d got=%b exp=0", it, running); end
        cmd    = int'($urandom_range(0, 2));
        start  = (cmd != 1);
        step   = (cmd != 0);
        stop   = 1'($urandom_range(0, 1));
        clr_sc = 1'($urandom_range(0, 1));
        ir     = 8'($urandom);
        tick();
        start = 1'b0; step = 1'b0; stop = 1'b0; clr_sc = 1'b0;
        model_run  = 1'b1;
        model_step = (cmd == 1);
      end
      ir_v = ($urandom_range(0, 3) == 0) ? 8'h70 : 8'($urandom);
      k    = int'($urandom_range(0, 10));
      s    = int'($urandom_range(0, 12));
      hlt  = (ir_v == 8'h70) && (k >= 3);
      e    = hlt ? 3 : k;
      for (int c = 0; c <= e; c++) begin
        ir = ir_v; clr_sc = (c == k); stop = (c == s);
        et = 8'h01 << (c % 8);
        checks++; if (T !== et) begin failures++; $display("FAIL rand_T it=%0d c=%0d got=%h exp=%h", it, c, T, et); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL rand_running it=%0d c=%0d got=%b exp=1", it, c, running); end
        if (c >= 3) begin
          ed = 8'h01 << ir_v[6:4];
          eb = {4'h0, ir_v[3:0]};
          checks++; if (D !== ed) begin failures++; $display("FAIL rand_D it=%0d c=%0d got=%h exp=%h", it, c, D, ed); end
          checks++; if (I !== ir_v[7]) begin failures++; $display("FAIL rand_I it=%0d c=%0d got=%b exp=%b", it, c, I, ir_v[7]); end
          checks++; if (B !== eb) begin failures++; $display("FAIL rand_B it=%0d c=%0d got=%h exp=%h", it, c, B, eb); end
        end
        tick();
      end
      clr_sc = 1'b0; stop = 1'b0;
      exp_count++;
      if (e >= 8) exp_ovf = 1'b1;
      halt = hlt || (s <= e) || model_step;
      if (halt) begin
        model_run  = 1'b0;
        model_step = 1'b0;
      end
      checks++; if (running !== model_run) begin failures++; $display("FAIL rand_boundary_run it=%0d got=%b exp=%b", it, running, model_run); end
      checks++; if (sc_overflow !== exp_ovf) begin failures++; $display("FAIL rand_ovf it=%0d got=%b exp=%b", it, sc_overflow, exp_ovf); end
      checks++; if (instr_count !== cnt_model()) begin failures++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, instr_count, cnt_model()); end
      if (model_run) begin
        checks++; if (T !== 8'h01) begin failures++; $display("FAIL rand_next_T0 it=%0d got=%h exp=01", it, T); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_instr();
    test_hlt();
    test_stop();
    test_step_cla();
    test_overflow();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
